// File: rtl/gray_conv_host_if.sv
// Host adapter for the iterative binary-to-Gray core: input FIFO, one-at-a-time
// start/done launch with watchdog, single-entry valid/ready result register.
module gray_conv_host_if #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             conv_start,
  output logic [WIDTH-1:0] conv_din,
  input  logic             conv_done,
  input  logic [WIDTH-1:0] conv_dout,
  output logic             busy,
  output logic             err_timeout,
  output logic [15:0]      conv_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  fifo_mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              head_avail_q;
  logic [TW-1:0]     wd_q;
  logic              conv_start_q;
  logic [WIDTH-1:0]  conv_din_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic              busy_q;
  logic              err_timeout_q;
  logic [15:0]       conv_count_q;

  logic push, pop, slot_free, capture;

  assign in_ready  = (count_q < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (state_q == S_IDLE) && head_avail_q;
  assign slot_free = !out_valid_q || out_ready;
  assign capture   = conv_done && slot_free && ((state_q == S_RUN) || (state_q == S_HOLD));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= in_data;
  end

  // The launcher sees occupancy one cycle late, so a fresh word is never
  // read on the same edge it is written and launch lands two edges after push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_avail_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_avail_q <= (count_q != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wd_q          <= '0;
      conv_start_q  <= 1'b0;
      conv_din_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      conv_count_q  <= '0;
    end else begin
      // A capture wins over an accept, so accept+capture keeps out_valid high.
      if (capture) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= conv_dout;
        conv_count_q <= conv_count_q + 16'd1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (head_avail_q) begin
            conv_din_q   <= fifo_mem[rd_ptr_q];
            conv_start_q <= 1'b1;
            wd_q         <= '0;
            busy_q       <= 1'b1;
            state_q      <= S_RUN;
          end
        end
        S_RUN: begin
          wd_q <= wd_q + TW'(1);
          if (capture) begin
            conv_start_q <= 1'b0;
            state_q      <= S_RELEASE;
          end else if (conv_done) begin
            state_q <= S_HOLD;
          end else if (wd_q == TW'(TIMEOUT - 1)) begin
            err_timeout_q <= 1'b1;
            conv_start_q  <= 1'b0;
            state_q       <= S_RELEASE;
          end
        end
        S_HOLD: begin
          // start stays high so the core keeps its result parked in DONE
          if (capture) begin
            conv_start_q <= 1'b0;
            state_q      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!conv_done) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign conv_start  = conv_start_q;
  assign conv_din    = conv_din_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign conv_count  = conv_count_q;

endmodule

// File: tb/tb_gray_conv_host_if.sv
// Scoreboard bench for gray_conv_host_if with a behavioural converter core
// that can be told to hang so the watchdog path is reachable.
module tb_gray_conv_host_if;

  localparam int CORE_LAT = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       conv_start;
  logic [7:0] conv_din;
  logic       conv_done;
  logic [7:0] conv_dout;
  logic       busy;
  logic       err_timeout;
  logic [15:0] conv_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [7:0] exp_q [$];

  logic       core_hang;
  logic [1:0] core_st;
  int         core_cnt;
  logic [7:0] core_opnd;

  always #5 clk = ~clk;

  gray_conv_host_if #(.WIDTH(8), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .conv_start (conv_start),
    .conv_din   (conv_din),
    .conv_done  (conv_done),
    .conv_dout  (conv_dout),
    .busy       (busy),
    .err_timeout(err_timeout),
    .conv_count (conv_count)
  );

  // Core model: idle -> busy (CORE_LAT cycles) -> done held while start=1.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_st   <= 2'd0;
      core_cnt  <= 0;
      core_opnd <= 8'h00;
      conv_done <= 1'b0;
      conv_dout <= 8'h00;
    end else begin
      case (core_st)
        2'd0: if (conv_start) begin
          core_st   <= 2'd1;
          core_cnt  <= CORE_LAT;
          core_opnd <= conv_din;
        end
        2'd1: begin
          if (!conv_start) core_st <= 2'd0;
          else if (!core_hang) begin
            if (core_cnt == 0) begin
              conv_done <= 1'b1;
              conv_dout <= core_opnd ^ (core_opnd >> 1);
              core_st   <= 2'd2;
            end else begin
              core_cnt <= core_cnt - 1;
            end
          end
        end
        default: if (!conv_start) begin
          conv_done <= 1'b0;
          core_st   <= 2'd0;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected result per accepted output.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h required none", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        $display("OUT %02h expected %02h", out_data, e);
        check("out_data", {24'h0, out_data}, {24'h0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d, input logic [7:0] g, input bit expect_out);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    w = 0;
    while (!in_ready && w < 300) begin
      tick();
      w++;
    end
    if (!in_ready) check("push_in_ready_wait", in_ready, 1);
    if (expect_out) begin
      exp_q.push_back(g);
      exp_count++;
    end
    tick();
    in_valid = 1'b0;
    $display("IN %02h", d);
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 400) begin
      tick();
      w++;
    end
    check(name, {31'h0, (exp_q.size() == 0 && !busy)}, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},    in_ready, 1);
    check({tag, "_out_valid"},   out_valid, 0);
    check({tag, "_out_data"},    out_data, 0);
    check({tag, "_conv_start"},  conv_start, 0);
    check({tag, "_conv_din"},    conv_din, 0);
    check({tag, "_busy"},        busy, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_conv_count"},  conv_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

  initial begin
    int w;
    int hi;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; core_hang = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    reset = 1'b0;
    tick();

    // Single word with launch timing: push at edge N, start at N+2.
    out_ready = 1'b1;
    push_word(8'hB6, 8'hED, 1'b1);
    check("launch_n0_start", conv_start, 0);
    tick();
    check("launch_n1_start", conv_start, 0);
    tick();
    check("launch_n2_start", conv_start, 1);
    check("launch_n2_din", conv_din, 8'hB6);
    check("busy_in_run", busy, 1);
    w = 0;
    while (!out_valid && w < 100) begin tick(); w++; end
    check("single_out_valid", out_valid, 1);
    check("single_start_dropped", conv_start, 0);
    check("single_count", conv_count, 1);
    tick();
    check("single_valid_one_cycle", out_valid, 0);
    wait_drain("single_drain");
    check("single_busy_idle", busy, 0);

    // Backpressure: second conversion parks in HOLD, then burst fills FIFO.
    out_ready = 1'b0;
    push_word(8'h0F, 8'h08, 1'b1);
    push_word(8'hF0, 8'h88, 1'b1);
    repeat (40) tick();
    check("bp_out_valid", out_valid, 1);
    check("bp_out_data", out_data, 8'h08);
    check("bp_hold_start", conv_start, 1);
    check("bp_hold_busy", busy, 1);
    check("bp_count", conv_count, 2);
    push_word(8'h00, 8'h00, 1'b1);
    push_word(8'hFF, 8'h80, 1'b1);
    push_word(8'h80, 8'hC0, 1'b1);
    push_word(8'h01, 8'h01, 1'b1);
    check("burst_full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (3) tick();
    in_valid = 1'b0;
    check("burst_still_full", in_ready, 0);
    out_ready = 1'b1;
    wait_drain("burst_drain");
    check("burst_count", conv_count, exp_count);

    // Watchdog: core never finishes, word is dropped after 16 RUN cycles.
    core_hang = 1'b1;
    push_word(8'h3C, 8'h00, 1'b0);
    hi = 0;
    w = 0;
    while (w < 100) begin
      tick();
      w++;
      if (conv_start) hi++;
      else if (hi > 0) break;
    end
    check("timeout_run_cycles", hi, 16);
    check("timeout_err", err_timeout, 1);
    check("timeout_no_output", out_valid, 0);
    core_hang = 1'b0;
    wait_drain("timeout_idle");
    check("timeout_count_unchanged", conv_count, exp_count);
    push_word(8'h3C, 8'h22, 1'b1);
    wait_drain("after_timeout_drain");
    check("timeout_err_sticky", err_timeout, 1);
    check("after_timeout_count", conv_count, exp_count);

    // Reset mid-RUN with three words still queued.
    push_word(8'h11, 8'h00, 1'b0);
    push_word(8'h22, 8'h00, 1'b0);
    push_word(8'h33, 8'h00, 1'b0);
    push_word(8'h44, 8'h00, 1'b0);
    check("pre_reset_running", conv_start, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("midrun");
    exp_count = 0;
    tick();
    tick();
    reset = 1'b0;
    repeat (40) tick();
    check("post_reset_no_launch", conv_start, 0);
    check("post_reset_idle", busy, 0);
    check("post_reset_count", conv_count, 0);
    push_word(8'h01, 8'h01, 1'b1);
    wait_drain("post_reset_drain");
    check("post_reset_one_conv", conv_count, 1);

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_conv_host_if.md
# gray_conv_host_if

Stream-side host adapter for the iterative binary-to-Gray converter core. It buffers incoming binary words in a small FIFO and launches one conversion at a time through the core's start/done handshake. Each result is captured into a single-entry output register and presented as a valid/ready stream. It sits directly upstream and downstream of the converter core: it drives `start` and the operand, and consumes `done` and the result. A watchdog aborts conversions that never complete.

## Interface
- WIDTH, 8: operand/result width in bits (the core iterates WIDTH-1 XOR steps).
- DEPTH, 4: input FIFO entries; power of two, ≥2.
- TIMEOUT, 64: maximum cycles in RUN before abort; must exceed core latency (3·WIDTH+2).
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  FIFO not full
- in_data  in  WIDTH  binary word
- out_valid  out  1  result register occupied
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  Gray-coded result
- conv_start  out  1  level start to core (registered)
- conv_din  out  WIDTH  operand to core, held stable for the whole conversion
- conv_done  in  1  core done level
- conv_dout  in  WIDTH  core result, valid while conv_done=1
- busy  out  1  FSM not in IDLE
- err_timeout  out  1  sticky; set on abort, cleared only by reset
- conv_count  out  16  completed conversions, wraps at 0xFFFF→0

## Operation
- Input FIFO: push when in_valid&&in_ready; in_ready = (count<DEPTH). A push and a pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- The FSM has four states: IDLE, RUN, HOLD, RELEASE.
- IDLE: if FIFO is non-empty, pop the head into conv_din, set conv_start=1, clear the watchdog, and go to RUN. Otherwise stay in IDLE.
- RUN: conv_start=1 and the watchdog increments.
  - On conv_done=1 with the output slot free (out_valid=0, or out_valid&&out_ready this cycle): load out_data←conv_dout, set out_valid=1, increment conv_count, drop conv_start, and go to RELEASE.
  - On conv_done=1 with the output slot full: go to HOLD.
  - If the watchdog reaches TIMEOUT-1 without conv_done: set err_timeout, drop conv_start, discard the word (no output, no count), and go to RELEASE.
- HOLD: conv_start stays 1, which keeps the core in its DONE state with the result stable. When the slot frees, capture exactly as in RUN and go to RELEASE. The watchdog does not run in HOLD.
- RELEASE: conv_start=0. Wait for conv_done=0, then go to IDLE. No launch occurs until the core has returned to idle.
- Output: out_valid clears on out_valid&&out_ready unless a capture happens in the same cycle. A simultaneous accept and capture leaves out_valid=1 with the new data.
- Results are delivered in input order. Exactly one output is produced per popped word, except for timed-out words.
- Reset mid-operation: all state returns to reset values immediately. FIFO contents and any in-flight word are lost. The core is reset by the same signal.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, conv_start=0, conv_din=0, busy=0, err_timeout=0, conv_count=0, FSM=IDLE, FIFO empty.
- All outputs are registered except in_ready, which is decoded from the registered count.
- Launch: conv_start rises the cycle after IDLE sees a non-empty FIFO. A word pushed into an empty FIFO at edge N produces conv_start=1 at edge N+2.
- Capture: out_valid rises on the edge that samples conv_done=1, and conv_start falls on that same edge.
- Back-to-back spacing is bounded by the core: RELEASE lasts until the core leaves DONE (≥1 cycle), then one IDLE cycle precedes the next start.
- busy=1 in RUN, HOLD, and RELEASE.

## Test plan
- Single word: push 0xB6 with out_ready=1 → out_data=0xED, out_valid for 1 cycle, conv_count=1, conv_start low after capture, busy returns to 0.
- Burst of 4 (0x00, 0xFF, 0x80, 0x01) with the FIFO filling → in_ready=0 while full; outputs are 0x00, 0x80, 0xC0, 0x01 in order, with no drops or duplicates.
- Backpressure: hold out_ready=0 across two conversions (0x0F then 0xF0) → second conversion sits in HOLD with conv_start=1; release out_ready → 0x08 accepted, then 0x88 captured.
- Timeout: core model never asserts done, TIMEOUT=16 → abort after 16 RUN cycles, err_timeout=1 and sticky, no out_valid; next word converts normally.
- Reset asserted mid-RUN with 3 words queued → all outputs return to reset values in the same cycle; FIFO empty; no spurious out_valid after release.
- Counter wrap: force 65 536 conversions (or preload in sim) → conv_count wraps to 0.
